// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Arbitrates one shared bus between two initiators and a split-capable target.
// The target can defer an initiator's transaction with split_ack. Later it
// returns the read data by requesting the bus itself with split_req. The
// deferred initiator stays locked out until that split data return completes.
//
// Optional feature (compile-time macro):
//   ARB_ROUND_ROBIN_EN  - when defined, simultaneous eligible init1/init2
//                         requests alternate. The first tie after reset goes
//                         to init1. When the macro is undefined, init1 always
//                         wins and there is no last-winner register.
//
// Parameters:
//   TIMEOUT_CYCLES - maximum number of cycles one grant may be held without
//                    txn_done before the grant is revoked.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   init1_req    in   initiator 1 bus request, held until its transaction ends
//   init2_req    in   initiator 2 bus request, held until its transaction ends
//   split_req    in   split target requests the bus to return deferred data
//   split_ack    in   pulse: the target deferred the current transaction
//   txn_done     in   pulse: the current transaction completed
//   init1_grant  out  registered grant to initiator 1
//   init2_grant  out  registered grant to initiator 2
//   split_grant  out  registered grant to the split target
//   owner        out  current master: 0 none, 1 init1, 2 init2, 3 split target
//   split_owner  out  initiator waiting for split data (0 none, 1, 2)
//   timeout      out  pulse in the cycle a grant is forcibly revoked
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init1_req,
  input  logic       init2_req,
  input  logic       split_req,
  input  logic       split_ack,
  input  logic       txn_done,
  output logic       init1_grant,
  output logic       init2_grant,
  output logic       split_grant,
  output logic [1:0] owner,
  output logic [1:0] split_owner,
  output logic       timeout
);

  // The hold counter is at least 8 bits wide. It is also wide enough to
  // reach TIMEOUT_CYCLES-1, so it can never saturate before the limit.
  localparam int HW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [HW-1:0] HOLD_LAST = HW'(TIMEOUT_CYCLES - 1);

  // The state encoding equals the owner code, so owner is a direct read of
  // the state register.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_I1    = 2'd1,
    BUSY_I2    = 2'd2,
    BUSY_SPLIT = 2'd3
  } state_t;

  state_t          state, state_next;
  logic            split_pending, split_pending_next;
  logic [1:0]      split_owner_next;
  logic [HW-1:0]   hold, hold_next;
  // armed is low for the first edge after reset. The first grant therefore
  // lands on the second rising edge at the earliest.
  logic            armed;
  logic            prefer_i2;

  logic            elig1, elig2;
  logic            owner_req;
  logic            split_take;
  logic            release_bus;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when init1 won the most recent initiator arbitration.
  logic            last_i1;

  assign prefer_i2 = last_i1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_i1 <= 1'b0;
    end else if (state == IDLE) begin
      if (state_next == BUSY_I1) begin
        last_i1 <= 1'b1;
      end else if (state_next == BUSY_I2) begin
        last_i1 <= 1'b0;
      end
    end
  end
`else
  assign prefer_i2 = 1'b0;
`endif

  // The initiator that was split off cannot re-arbitrate until its data
  // has been returned.
  assign elig1 = init1_req && !(split_pending && (split_owner == 2'd1));
  assign elig2 = init2_req && !(split_pending && (split_owner == 2'd2));

  // A second split_ack, or one that arrives while the split target owns the
  // bus, is ignored.
  assign split_take = split_ack && !split_pending &&
                      ((state == BUSY_I1) || (state == BUSY_I2));

  always_comb begin
    // NOTE: every variable assigned here gets a default first. Otherwise a
    // path that skips an assignment would infer a latch.
    state_next         = state;
    split_pending_next = split_pending;
    split_owner_next   = split_owner;
    hold_next          = hold;
    timeout            = 1'b0;
    release_bus        = 1'b0;
    owner_req          = 1'b0;

    case (state)
      BUSY_I1:    owner_req = init1_req;
      BUSY_I2:    owner_req = init2_req;
      BUSY_SPLIT: owner_req = split_req;
      default:    owner_req = 1'b0;
    endcase

    if (state == IDLE) begin
      // The counter is cleared here, so it reads 0 in the first BUSY cycle.
      hold_next = '0;
      if (armed) begin
        if (split_pending && split_req) begin
          state_next = BUSY_SPLIT;
        end else if (elig1 && elig2) begin
          state_next = prefer_i2 ? BUSY_I2 : BUSY_I1;
        end else if (elig1) begin
          state_next = BUSY_I1;
        end else if (elig2) begin
          state_next = BUSY_I2;
        end
      end
    end else begin
      // split_ack takes precedence over a txn_done in the same cycle.
      if (split_take) begin
        split_pending_next = 1'b1;
        split_owner_next   = (state == BUSY_I1) ? 2'd1 : 2'd2;
        state_next         = IDLE;
      end else if (txn_done) begin
        release_bus = 1'b1;
      end else if (hold == HOLD_LAST) begin
        timeout     = 1'b1;
        release_bus = 1'b1;
      end else if (!owner_req) begin
        release_bus = 1'b1;
      end else begin
        hold_next = hold + HW'(1);
      end

      // Going through IDLE guarantees one cycle with every grant low.
      if (release_bus) begin
        state_next = IDLE;
        if (state == BUSY_SPLIT) begin
          split_pending_next = 1'b0;
          split_owner_next   = 2'd0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      split_pending <= 1'b0;
      split_owner   <= 2'd0;
      hold          <= '0;
      armed         <= 1'b0;
    end else begin
      state         <= state_next;
      split_pending <= split_pending_next;
      split_owner   <= split_owner_next;
      hold          <= hold_next;
      armed         <= 1'b1;
    end
  end

  assign init1_grant = (state == BUSY_I1);
  assign init2_grant = (state == BUSY_I2);
  assign split_grant = (state == BUSY_SPLIT);
  assign owner       = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter, instantiated with TIMEOUT_CYCLES = 8.
// A behavioural model tracks:
//   - the bus owner as an integer,
//   - the split bookkeeping,
//   - the grant age,
//   - the last initiator winner.
// Each cycle, every DUT output is compared against this model. Directed
// scenarios cover the documented behaviours. A randomized phase follows them.
// Define ARB_ROUND_ROBIN_EN here as well when building the round-robin variant.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TO = 8;

  logic       clk;
  logic       rst;
  logic       init1_req, init2_req, split_req, split_ack, txn_done;
  logic       init1_grant, init2_grant, split_grant, timeout;
  logic [1:0] owner, split_owner;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .init1_req   (init1_req),
    .init2_req   (init2_req),
    .split_req   (split_req),
    .split_ack   (split_ack),
    .txn_done    (txn_done),
    .init1_grant (init1_grant),
    .init2_grant (init2_grant),
    .split_grant (split_grant),
    .owner       (owner),
    .split_owner (split_owner),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec  = 0;
  int    n_miss = 0;
  string phase  = "init";

  // Reference model state.
  int m_owner;   // 0 none, 1 init1, 2 init2, 3 split target
  int m_sown;    // initiator awaiting split data
  bit m_pend;    // split data outstanding
  int m_hold;    // completed cycles of the current grant
  int m_last;    // last initiator granted (0 = none since reset)
  bit m_ready;   // one edge has passed since reset released

  // DUT outputs sampled in the most recent cycle.
  bit s_g1, s_g2, s_gs, s_to;
  int s_owner;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_sown  = 0;
    m_pend  = 1'b0;
    m_hold  = 0;
    m_last  = 0;
    m_ready = 1'b0;
  endtask

  // Entered at posedge+1. Asserts reset asynchronously, checks outputs at once,
  // and releases reset one edge later (again at posedge+1).
  task automatic do_reset();
    rst       = 1'b1;
    init1_req = 1'b0;
    init2_req = 1'b0;
    split_req = 1'b0;
    split_ack = 1'b0;
    txn_done  = 1'b0;
    #1;
    check("reset_outs", {23'd0, init1_grant, init2_grant, split_grant, owner, split_owner, timeout}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle. It is entered at posedge+1 and returns at posedge+1.
  // Outputs are compared at the falling edge. The model then moves on using
  // the inputs seen by the DUT at the rising edge.
  task automatic cycle(input bit i1, input bit i2, input bit sr, input bit sa, input bit td);
    bit         sack_ok, to_exp, still;
    logic [8:0] exp_v, got_v;
    int         pick;
    init1_req = i1;
    init2_req = i2;
    split_req = sr;
    split_ack = sa;
    txn_done  = td;
    @(negedge clk);
    sack_ok = sa && !m_pend && (m_owner == 1 || m_owner == 2);
    to_exp  = (m_owner != 0) && (m_hold == TO - 1) && !td && !sack_ok;
    exp_v   = {m_owner == 1, m_owner == 2, m_owner == 3, 2'(m_owner), 2'(m_sown), to_exp};
    got_v   = {init1_grant, init2_grant, split_grant, owner, split_owner, timeout};
    s_g1    = init1_grant;
    s_g2    = init2_grant;
    s_gs    = split_grant;
    s_to    = timeout;
    s_owner = int'(owner);
    check(phase, 32'(got_v), 32'(exp_v));
    @(posedge clk);
    if (!m_ready) begin
      m_ready = 1'b1;
    end else if (m_owner == 0) begin
      // Arbitration from an idle bus.
      bit e1, e2;
      e1 = i1 && !(m_pend && m_sown == 1);
      e2 = i2 && !(m_pend && m_sown == 2);
`ifdef ARB_ROUND_ROBIN_EN
      pick = (m_last == 1) ? 2 : 1;
`else
      pick = 1;
`endif
      if (m_pend && sr)  m_owner = 3;
      else if (e1 && e2) m_owner = pick;
      else if (e1)       m_owner = 1;
      else if (e2)       m_owner = 2;
      if (m_owner == 1 || m_owner == 2) m_last = m_owner;
      m_hold = 0;
    end else begin
      still = (m_owner == 1) ? i1 : (m_owner == 2) ? i2 : sr;
      if (sack_ok) begin
        m_pend  = 1'b1;
        m_sown  = m_owner;
        m_owner = 0;
      end else if (td || to_exp || !still) begin
        if (m_owner == 3) begin
          m_pend = 1'b0;
          m_sown = 0;
        end
        m_owner = 0;
      end else begin
        m_hold++;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, wins, code;
    bit r1, r2, rs;

    rst       = 1'b1;
    init1_req = 1'b0;
    init2_req = 1'b0;
    split_req = 1'b0;
    split_ack = 1'b0;
    txn_done  = 1'b0;
    model_reset();

    // Power-up reset. Then a request held from the first cycle: no grant
    // after the first edge, a grant after the second.
    phase = "reset";
    do_reset();
    phase = "first_grant";
    cycle(1, 0, 0, 0, 0);
    #0 check("first_edge_no_grant", 32'(init1_grant), 32'd0);
    cycle(1, 0, 0, 0, 0);
    check("second_edge_grant", 32'(init1_grant), 32'd1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // A single init1 transaction lasting five cycles, then a turnaround.
    phase = "single_txn";
    do_reset();
    repeat (4) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0, 0, k == 4);
      n += int'(s_g1);
    end
    check("single_txn_len", 32'(n), 32'd5);
    cycle(0, 0, 0, 0, 0);
    check("single_txn_turnaround", 32'({s_g1, s_g2, s_gs}), 32'd0);

    // Both initiators requesting across three transactions.
    phase = "contention";
    do_reset();
    cycle(1, 1, 0, 0, 0);
    wins = 0;
    code = 0;
    for (int k = 0; k < 20 && wins < 3; k++) begin
      cycle(1, 1, 0, 0, m_owner != 0);
      if (s_owner != 0) begin
        code = code * 10 + s_owner;
        wins++;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("contention_order", 32'(code), 32'd121);
`else
    check("contention_order", 32'(code), 32'd111);
`endif
    cycle(0, 0, 0, 0, 0);

    // A split transaction: init1 is deferred, init2 gets the bus, the split
    // target returns the data, and only then is init1 granted again.
    phase = "split_flow";
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    check("split_owner_loaded", 32'(split_owner), 32'd1);
    cycle(1, 1, 0, 0, 0);
    check("split_i2_granted", 32'(init2_grant), 32'd1);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 1);
    cycle(1, 0, 1, 0, 0);
    check("split_grant_after_i2", 32'(split_grant), 32'd1);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 1);
    check("split_owner_cleared", 32'(split_owner), 32'd0);
    cycle(1, 0, 0, 0, 0);
    check("split_i1_regrant", 32'(init1_grant), 32'd1);
    cycle(0, 0, 0, 0, 0);

    // A held grant with no txn_done: timeout in the 8th busy cycle.
    phase = "timeout";
    do_reset();
    cycle(0, 1, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(0, 1, 0, 0, 0);
      n += int'(s_g2);
      if (s_to) break;
    end
    check("timeout_cycle", 32'(n), 32'(TO));
    check("timeout_grant_drop", 32'(init2_grant), 32'd0);
    cycle(0, 0, 0, 0, 0);

    // split_ack together with txn_done, then reset in the middle of BUSY_SPLIT.
    phase = "ack_done_reset";
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1);
    check("ack_done_sown", 32'(split_owner), 32'd1);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    check("in_busy_split", 32'(split_grant), 32'd1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 0, 0);
      check("stray_split_ignored", 32'(s_gs), 32'd0);
    end

    // Randomized traffic with occasional resets.
    phase = "random";
    do_reset();
    r1 = 1'b0;
    r2 = 1'b0;
    rs = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(299) == 0) do_reset();
      if (!r1) r1 = ($urandom_range(3) == 0); else if ($urandom_range(15) == 0) r1 = 1'b0;
      if (!r2) r2 = ($urandom_range(3) == 0); else if ($urandom_range(15) == 0) r2 = 1'b0;
      if (!rs) rs = ($urandom_range(5) == 0); else if ($urandom_range(7) == 0) rs = 1'b0;
      cycle(r1, r2, rs, $urandom_range(7) == 0, (m_owner != 0) && ($urandom_range(9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum cycles one grant may be held without txn_done.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 init1_req, init2_req  in  1 each  initiator bus request; held until the transaction ends.
REQ-006 split_req  in  1  split target request to return deferred read data.
REQ-007 split_ack  in  1  one-cycle pulse: the addressed target deferred the current transaction.
REQ-008 txn_done  in  1  one-cycle pulse: the current transaction completed (target ack).
REQ-009 init1_grant, init2_grant, split_grant  out  1 each  registered one-hot grants.
REQ-010 owner  out  2  current bus master: 0 none, 1 init1, 2 init2, 3 split target.
REQ-011 split_owner  out  2  initiator awaiting split data: 0 none, 1 init1, 2 init2; drives return-data routing.
REQ-012 timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-013 State machine states SHALL be IDLE, BUSY_I1, BUSY_I2 and BUSY_SPLIT; grants and owner SHALL decode directly from state registers.
REQ-014 In IDLE, eligible requests SHALL be evaluated each cycle and the next state entered on the following edge; grant latency from req to grant SHALL be 1 cycle.
REQ-015 Priority SHALL be: split_req with split_pending set first, then initiators per REQ-031/REQ-032.
REQ-016 An initiator equal to split_owner SHALL be ineligible while split_pending is set.
REQ-017 split_req with split_pending clear SHALL be ignored.
REQ-018 A BUSY state SHALL return to IDLE on txn_done, on deassertion of the owner's req, or on timeout.
REQ-019 Every return to IDLE SHALL insert at least one cycle with all grants low (turnaround).
REQ-020 split_ack in BUSY_I1 or BUSY_I2 SHALL set split_pending, load split_owner with the current initiator, and return to IDLE.
REQ-021 split_ack and txn_done in the same cycle SHALL be treated as split_ack.
REQ-022 split_ack outside BUSY_I1 or BUSY_I2, or while split_pending is already set, SHALL be ignored.
REQ-023 Leaving BUSY_SPLIT SHALL clear split_pending and reset split_owner to 0 in the same edge.
REQ-024 split_owner SHALL remain stable from split_ack until BUSY_SPLIT exits.
REQ-025 An 8-bit-or-wider hold counter SHALL clear on entry to any BUSY state and increment each BUSY cycle; saturation SHALL be impossible before TIMEOUT_CYCLES.
REQ-026 When the hold counter reaches TIMEOUT_CYCLES-1 without txn_done, the block SHALL pulse timeout and return to IDLE.
REQ-027 A timeout in BUSY_SPLIT SHALL also clear split_pending.
REQ-028 Requests that arrive while BUSY SHALL be held pending, not dropped, as long as req stays asserted.

Reset
REQ-029 When rst is asserted, the block SHALL immediately force state IDLE, all grants 0, owner 0, split_owner 0, split_pending 0, timeout 0, hold counter 0 and last-winner 0, including during a transaction.
REQ-030 The first grant after rst deasserts SHALL occur no earlier than the second rising edge.

Configuration
REQ-031 With macro ARB_ROUND_ROBIN_EN defined, simultaneous eligible init1 and init2 requests SHALL be granted to the initiator not granted last; after reset, init1 wins.
REQ-032 Without ARB_ROUND_ROBIN_EN, init1 SHALL always win over init2 (fixed priority); the last-winner register SHALL be absent.

Verification
REQ-033 init1_req at cycle 10, txn_done at cycle 15 -> init1_grant high cycles 11-15, owner=1, then 1 idle cycle with all grants low.
REQ-034 init1_req and init2_req both held across 3 transactions -> fixed: grants I1,I1,I1; with ARB_ROUND_ROBIN_EN: I1,I2,I1.
REQ-035 init1 granted, split_ack pulse, init2_req held, then split_req 4 cycles later -> split_owner=1, init2 granted before split_req, split_grant after init2 releases, and init1 is not granted until split_owner returns to 0.
REQ-036 init2 granted and no txn_done with TIMEOUT_CYCLES=8 -> timeout pulses on the 8th BUSY cycle and init2_grant drops the next edge.
REQ-037 rst asserted mid-BUSY_SPLIT -> all outputs 0 asynchronously and split_owner=0; a stray split_req after reset is ignored.
REQ-038 split_ack and txn_done in the same cycle -> split_pending set and split_owner loaded.
